ext_arbiter: RTL

- Shares one immediate-extension datapath between two requesters: decode path (req 0) and branch-target path (req 1).
- Round-robin grant, valid/ready handshake on both sides, one registered output stage.
- Per-requester saturating service counters for debug/perf readout.
- Sits between the instruction-field split and the ALU-B/NPC operand muxes.

---
 rtl/ext_arbiter_pkg.sv | 35 +++
 rtl/ext_arbiter_rr_arb2.sv | 47 ++++
 rtl/ext_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ext_arbiter_pkg.sv
// Shared definitions for the immediate-extension arbiter: extension op
// encodings, requester indices, datapath widths and the extension function.
package ext_arbiter_pkg;

  localparam int unsigned IMM_W = 16;
  localparam int unsigned RES_W = 32;

  // Requester indices
  localparam logic REQ_DEC = 1'b0;
  localparam logic REQ_BR  = 1'b1;

  // Extension op encodings
  typedef enum logic [1:0] {
    EOP_SEXT     = 2'b00,
    EOP_ZEXT     = 2'b01,
    EOP_LUI      = 2'b10,
    EOP_SEXT_SL2 = 2'b11
  } eop_e;

  // Produce the 32-bit extended immediate for one 16-bit field and op
  function automatic logic [RES_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                               input eop_e eop);
    logic [RES_W-1:0] res;
    res = {RES_W{1'b0}};
    case (eop)
      EOP_SEXT:     res = {{16{imm[15]}}, imm};
      EOP_ZEXT:     res = {16'h0000, imm};
      EOP_LUI:      res = {imm, 16'h0000};
      EOP_SEXT_SL2: res = {{14{imm[15]}}, imm, 2'b00};
      default:      res = {RES_W{1'b0}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ext_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone request is always granted; when both
// request, the one not granted last time wins. The history bit only moves
// when the caller reports that the grant was actually consumed.
module rr_arb2 #(
  parameter bit FIRST_GNT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_gnt_q;
  logic last_gnt_d;

  // Grant decode from the current requests and the last winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // History update: remember the winner only when the grant was taken
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (advance && (gnt != 2'b00)) begin
      last_gnt_d = gnt[1];
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Last-winner register; reset value makes FIRST_GNT win the first contest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= ~FIRST_GNT;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/ext_arbiter.sv
// Shares one immediate-extension datapath between the decode path (req 0)
// and the branch-target path (req 1). Round-robin grant, valid/ready on both
// sides, a single registered result stage and saturating service counters.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter bit          FIRST_GNT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [31:0]      req_imm,
  input  logic [3:0]       req_eop,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ext,
  output logic             out_id,
  output logic [CNT_W-1:0] svc_cnt0,
  output logic [CNT_W-1:0] svc_cnt1
);

  logic [1:0]       gnt_s;
  logic             can_accept_s;
  logic             accept_s;
  logic             sel_s;
  logic [IMM_W-1:0] imm_sel_s;
  logic [1:0]       eop_sel_s;
  logic [RES_W-1:0] ext_s;

  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_ext_q,   out_ext_d;
  logic             out_id_q,    out_id_d;
  logic [CNT_W-1:0] cnt0_q,      cnt0_d;
  logic [CNT_W-1:0] cnt1_q,      cnt1_d;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rr_arb2 #(
    .FIRST_GNT (FIRST_GNT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept_s),
    .gnt     (gnt_s)
  );

  // Handshake: the result slot is free when empty or being drained now;
  // ready is forced low while reset is held
  always_comb begin
    can_accept_s = !out_valid_q || out_ready;
    if (rst_n && can_accept_s) begin
      req_ready = gnt_s;
    end else begin
      req_ready = 2'b00;
    end
    accept_s = |(req_valid & req_ready);
    sel_s    = req_ready[1];
  end

  // Extension datapath on the granted requester's fields
  always_comb begin
    if (sel_s == REQ_BR) begin
      imm_sel_s = req_imm[31:16];
      eop_sel_s = req_eop[3:2];
    end else begin
      imm_sel_s = req_imm[15:0];
      eop_sel_s = req_eop[1:0];
    end
    ext_s = ext_imm(imm_sel_s, eop_e'(eop_sel_s));
  end

  // Result stage next-state: load on accept, clear valid on a bare drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_ext_d   = out_ext_q;
    out_id_d    = out_id_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_ext_d   = ext_s;
      out_id_d    = sel_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Service counters next-state, saturating at all-ones
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req_ready[0] && req_valid[0] && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_ONE;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (req_ready[1] && req_valid[1] && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_ONE;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // State registers; async reset discards any pending result and counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ext_q   <= {RES_W{1'b0}};
      out_id_q    <= 1'b0;
      cnt0_q      <= {CNT_W{1'b0}};
      cnt1_q      <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_ext_q   <= out_ext_d;
      out_id_q    <= out_id_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ext   = out_ext_q;
  assign out_id    = out_id_q;
  assign svc_cnt0  = cnt0_q;
  assign svc_cnt1  = cnt1_q;

endmodule
